// File: rtl/pcs_257b_tx_generator.sv
// rtl/pcs_257b_tx_generator.sv - 66b block generator with 256b/257b transcoding and scrambling
// Eight 66b blocks per cycle in two groups of four; each group is transcoded to 257b, then scrambled.
module pcs_257b_tx_generator #(
  parameter int DATA_WIDTH           = 64,
  parameter int HDR_WIDTH            = 2,
  parameter int FRAME_WIDTH          = DATA_WIDTH + HDR_WIDTH,
  parameter int CONTROL_WIDTH        = 8,
  parameter int TRANSCODER_BLOCKS    = 4,
  parameter int TRANSCODER_WIDTH     = 257,
  parameter int TRANSCODER_HDR_WIDTH = 4,
  parameter int PROB                 = 30
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic [DATA_WIDTH-1:0]        i_txd,
  input  logic [CONTROL_WIDTH-1:0]     i_txc,
  input  logic [TRANSCODER_BLOCKS-1:0] i_data_sel_0,
  input  logic [TRANSCODER_BLOCKS-1:0] i_data_sel_1,
  input  logic [2:0]                   i_valid,
  input  logic                         i_enable,
  input  logic                         i_random_0,
  input  logic                         i_random_1,
  input  logic                         i_tx_test_mode,
  output logic [FRAME_WIDTH-1:0]       o_frame_0,
  output logic [FRAME_WIDTH-1:0]       o_frame_1,
  output logic [FRAME_WIDTH-1:0]       o_frame_2,
  output logic [FRAME_WIDTH-1:0]       o_frame_3,
  output logic [FRAME_WIDTH-1:0]       o_frame_4,
  output logic [FRAME_WIDTH-1:0]       o_frame_5,
  output logic [FRAME_WIDTH-1:0]       o_frame_6,
  output logic [FRAME_WIDTH-1:0]       o_frame_7,
  output logic [TRANSCODER_WIDTH-1:0]  o_tx_coded_f0,
  output logic [TRANSCODER_WIDTH-1:0]  o_tx_coded_f1,
  output logic [TRANSCODER_WIDTH-1:0]  o_tx_scrambled_f0,
  output logic [TRANSCODER_WIDTH-1:0]  o_tx_scrambled_f1
);

  localparam int NUM_FRAMES = 2 * TRANSCODER_BLOCKS;
  localparam int SCR_WIDTH  = 58;
  localparam int CTRL_CHUNK = DATA_WIDTH - 4;

  localparam logic [HDR_WIDTH-1:0]  HDR_DATA      = 2'b01;
  localparam logic [HDR_WIDTH-1:0]  HDR_CTRL      = 2'b10;
  localparam logic [DATA_WIDTH-1:0] DATA_PAYLOAD  = {8{8'hAA}};
  localparam logic [DATA_WIDTH-1:0] IDLE_PAYLOAD  = 64'h1E00_0000_0000_0000;
  localparam logic [DATA_WIDTH-1:0] ERROR_PAYLOAD = {8'h1E, {8{7'h1E}}};
  localparam logic [DATA_WIDTH-1:0] XGMII_IDLE    = {8{8'h07}};
  localparam logic [31:0]           LFSR_SEED     = 32'hACE1_2468;
  localparam logic [31:0]           LFSR_TAPS     = 32'h8020_0003;

  logic [FRAME_WIDTH-1:0]      frame_q [NUM_FRAMES];
  logic [FRAME_WIDTH-1:0]      frame_d [NUM_FRAMES];
  logic [31:0]                 lfsr_q;
  logic [31:0]                 lfsr_n;
  logic [TRANSCODER_WIDTH-1:0] coded_q [2];
  logic [TRANSCODER_WIDTH-1:0] scram_q [2];
  logic [SCR_WIDTH-1:0]        scr_state_q [2];
  logic [SCR_WIDTH+TRANSCODER_WIDTH-1:0] scr_next [2];
  logic [TRANSCODER_WIDTH-1:0] coded_d [2];
  logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] grp [2];

  logic [1:0]                             grp_valid;
  logic [1:0]                             grp_random;
  logic [1:0][TRANSCODER_BLOCKS-1:0]      grp_sel;

  assign grp_valid  = i_valid[1:0];
  assign grp_random = {i_random_1, i_random_0};
  assign grp_sel    = {i_data_sel_1, i_data_sel_0};

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] int_block(input logic is_data);
    return is_data ? {HDR_DATA, DATA_PAYLOAD} : {HDR_CTRL, IDLE_PAYLOAD};
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] ext_block(input logic [DATA_WIDTH-1:0] txd,
                                                       input logic [CONTROL_WIDTH-1:0] txc);
    if (txc == '0)
      return {HDR_DATA, txd};
    else if (txc == '1 && txd == XGMII_IDLE)
      return {HDR_CTRL, IDLE_PAYLOAD};
    else
      return {HDR_CTRL, ERROR_PAYLOAD};
  endfunction

  // Blocks are appended MSB-first by shifting; the first control block drops its type high nibble.
  function automatic logic [TRANSCODER_WIDTH-1:0] transcode(
      input logic [TRANSCODER_BLOCKS-1:0][FRAME_WIDTH-1:0] blk);
    logic [TRANSCODER_HDR_WIDTH-1:0] flags;
    logic [TRANSCODER_WIDTH-1:0]     acc;
    logic                            seen_ctrl;
    for (int k = 0; k < TRANSCODER_BLOCKS; k++)
      flags[TRANSCODER_BLOCKS-1-k] = (blk[k][FRAME_WIDTH-1 -: HDR_WIDTH] == HDR_DATA);
    acc       = (&flags) ? TRANSCODER_WIDTH'(1) : TRANSCODER_WIDTH'({1'b0, flags});
    seen_ctrl = 1'b0;
    for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
      if (!flags[TRANSCODER_BLOCKS-1-k] && !seen_ctrl) begin
        acc       = (acc << CTRL_CHUNK) | TRANSCODER_WIDTH'(blk[k][CTRL_CHUNK-1:0]);
        seen_ctrl = 1'b1;
      end else begin
        acc = (acc << DATA_WIDTH) | TRANSCODER_WIDTH'(blk[k][DATA_WIDTH-1:0]);
      end
    end
    return acc;
  endfunction

  // Self-synchronous 1 + x^39 + x^58; state[0] holds the most recent output bit.
  function automatic logic [SCR_WIDTH+TRANSCODER_WIDTH-1:0] scramble(
      input logic [TRANSCODER_WIDTH-1:0] d, input logic [SCR_WIDTH-1:0] s_in);
    logic [SCR_WIDTH-1:0]        s;
    logic [TRANSCODER_WIDTH-1:0] q;
    logic                        b;
    s = s_in;
    for (int i = TRANSCODER_WIDTH - 1; i >= 0; i--) begin
      b    = d[i] ^ s[38] ^ s[57];
      q[i] = b;
      s    = {s[SCR_WIDTH-2:0], b};
    end
    return {s, q};
  endfunction

  always_comb begin
    lfsr_n = lfsr_q;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      frame_d[i] = frame_q[i];
      if (grp_valid[i / TRANSCODER_BLOCKS]) begin
        if (!i_enable) begin
          frame_d[i] = ext_block(i_txd, i_txc);
        end else if (grp_random[i / TRANSCODER_BLOCKS]) begin
          lfsr_n     = lfsr_step(lfsr_n);
          frame_d[i] = int_block((lfsr_n % 32'd100) >= 32'(PROB));
        end else begin
          frame_d[i] = int_block(grp_sel[i / TRANSCODER_BLOCKS][i % TRANSCODER_BLOCKS]);
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < TRANSCODER_BLOCKS; k++)
        grp[g][k] = frame_q[g * TRANSCODER_BLOCKS + k];
      coded_d[g]  = transcode(grp[g]);
      scr_next[g] = scramble(coded_q[g], scr_state_q[g]);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= LFSR_SEED;
      for (int i = 0; i < NUM_FRAMES; i++)
        frame_q[i] <= '0;
      for (int g = 0; g < 2; g++) begin
        coded_q[g]     <= '0;
        scram_q[g]     <= '0;
        scr_state_q[g] <= '1;
      end
    end else begin
      lfsr_q <= lfsr_n;
      for (int i = 0; i < NUM_FRAMES; i++)
        frame_q[i] <= frame_d[i];
      if (i_valid[2]) begin
        for (int g = 0; g < 2; g++) begin
          coded_q[g] <= coded_d[g];
          if (i_tx_test_mode) begin
            scram_q[g] <= coded_q[g];
          end else begin
            scram_q[g]     <= scr_next[g][TRANSCODER_WIDTH-1:0];
            scr_state_q[g] <= scr_next[g][SCR_WIDTH+TRANSCODER_WIDTH-1:TRANSCODER_WIDTH];
          end
        end
      end
    end
  end

  assign o_frame_0         = frame_q[0];
  assign o_frame_1         = frame_q[1];
  assign o_frame_2         = frame_q[2];
  assign o_frame_3         = frame_q[3];
  assign o_frame_4         = frame_q[4];
  assign o_frame_5         = frame_q[5];
  assign o_frame_6         = frame_q[6];
  assign o_frame_7         = frame_q[7];
  assign o_tx_coded_f0     = coded_q[0];
  assign o_tx_coded_f1     = coded_q[1];
  assign o_tx_scrambled_f0 = scram_q[0];
  assign o_tx_scrambled_f1 = scram_q[1];

endmodule

// File: tb/tb_pcs_257b_tx_generator.sv
// tb/tb_pcs_257b_tx_generator.sv - scoreboard bench for pcs_257b_tx_generator
// Reference model builds 257b blocks as bit lists and scrambles with a ring buffer of past outputs.
module tb_pcs_257b_tx_generator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  i_txd;
  logic [7:0]   i_txc;
  logic [3:0]   i_data_sel_0, i_data_sel_1;
  logic [2:0]   i_valid;
  logic         i_enable, i_random_0, i_random_1, i_tx_test_mode;
  logic [65:0]  o_frame_0, o_frame_1, o_frame_2, o_frame_3;
  logic [65:0]  o_frame_4, o_frame_5, o_frame_6, o_frame_7;
  logic [256:0] o_tx_coded_f0, o_tx_coded_f1, o_tx_scrambled_f0, o_tx_scrambled_f1;

  always #5 clk = ~clk;

  pcs_257b_tx_generator dut (
    .clk(clk), .i_rst_n(rst_n), .i_txd(i_txd), .i_txc(i_txc),
    .i_data_sel_0(i_data_sel_0), .i_data_sel_1(i_data_sel_1), .i_valid(i_valid),
    .i_enable(i_enable), .i_random_0(i_random_0), .i_random_1(i_random_1),
    .i_tx_test_mode(i_tx_test_mode),
    .o_frame_0(o_frame_0), .o_frame_1(o_frame_1), .o_frame_2(o_frame_2), .o_frame_3(o_frame_3),
    .o_frame_4(o_frame_4), .o_frame_5(o_frame_5), .o_frame_6(o_frame_6), .o_frame_7(o_frame_7),
    .o_tx_coded_f0(o_tx_coded_f0), .o_tx_coded_f1(o_tx_coded_f1),
    .o_tx_scrambled_f0(o_tx_scrambled_f0), .o_tx_scrambled_f1(o_tx_scrambled_f1)
  );

  localparam logic [65:0] DATA_BLK = {2'b01, {8{8'hAA}}};
  localparam logic [65:0] CTRL_BLK = {2'b10, 64'h1E00_0000_0000_0000};
  localparam logic [65:0] ERR_BLK  = {2'b10, 8'h1E, {8{7'h1E}}};

  typedef struct packed {
    logic               tally;
    logic [7:0][65:0]   fr;
    logic [1:0][256:0]  cod;
    logic [1:0][256:0]  scr;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           ctl_blocks = 0;
  int           tally_blocks = 0;

  logic [65:0]  m_fr [8];
  logic [256:0] m_cod [2];
  logic [256:0] m_scr [2];
  logic [31:0]  m_lfsr;
  bit           ring [2][58];
  int           rpos [2];

  logic [65:0]  af [8];
  assign af[0] = o_frame_0; assign af[1] = o_frame_1; assign af[2] = o_frame_2; assign af[3] = o_frame_3;
  assign af[4] = o_frame_4; assign af[5] = o_frame_5; assign af[6] = o_frame_6; assign af[7] = o_frame_7;

  task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_fr[i] = '0;
    for (int g = 0; g < 2; g++) begin
      m_cod[g] = '0;
      m_scr[g] = '0;
      rpos[g]  = 0;
      for (int j = 0; j < 58; j++) ring[g][j] = 1'b1;
    end
    m_lfsr = 32'hACE1_2468;
  endtask

  // Output bit t = input ^ output(t-39) ^ output(t-58); ring holds the last 58 outputs.
  task automatic scr_model(input int g, input logic [256:0] d, output logic [256:0] q);
    for (int i = 256; i >= 0; i--) begin
      bit o;
      o = d[i] ^ ring[g][(rpos[g] + 19) % 58] ^ ring[g][rpos[g]];
      ring[g][rpos[g]] = o;
      rpos[g] = (rpos[g] + 1) % 58;
      q[i] = o;
    end
  endtask

  function automatic logic [256:0] xcode_model(input int g);
    bit           bits[$];
    bit           first_ctrl;
    bit           all_data;
    logic [256:0] r;
    all_data = 1;
    for (int k = 0; k < 4; k++) if (m_fr[4*g+k][65:64] != 2'b01) all_data = 0;
    bits.push_back(all_data);
    if (!all_data)
      for (int k = 0; k < 4; k++) bits.push_back(m_fr[4*g+k][65:64] == 2'b01);
    first_ctrl = 1;
    for (int k = 0; k < 4; k++) begin
      int top;
      top = 63;
      if (!all_data && m_fr[4*g+k][65:64] != 2'b01 && first_ctrl) begin
        top = 59;
        first_ctrl = 0;
      end
      for (int b = top; b >= 0; b--) bits.push_back(m_fr[4*g+k][b]);
    end
    r = '0;
    for (int i = 0; i < bits.size() && i < 257; i++) r[256-i] = bits[i];
    return r;
  endfunction

  function automatic logic [65:0] ext_model(input logic [63:0] txd, input logic [7:0] txc);
    if (txc == 8'h00) return {2'b01, txd};
    if (txc == 8'hFF && txd == {8{8'h07}}) return CTRL_BLK;
    return ERR_BLK;
  endfunction

  task automatic cyc(input logic [2:0] v, input logic en, input logic [3:0] s0, input logic [3:0] s1,
                     input logic r0, input logic r1, input logic tm,
                     input logic [63:0] txd, input logic [7:0] txc, input bit tally);
    exp_t e;
    @(negedge clk);
    i_valid = v; i_enable = en; i_data_sel_0 = s0; i_data_sel_1 = s1;
    i_random_0 = r0; i_random_1 = r1; i_tx_test_mode = tm; i_txd = txd; i_txc = txc;
    if (v[2]) begin
      for (int g = 0; g < 2; g++) begin
        if (tm) m_scr[g] = m_cod[g];
        else scr_model(g, m_cod[g], m_scr[g]);
        m_cod[g] = xcode_model(g);
      end
    end
    for (int i = 0; i < 8; i++) begin
      int g;
      g = i / 4;
      if (v[g]) begin
        if (!en) begin
          m_fr[i] = ext_model(txd, txc);
        end else if ((g == 0) ? r0 : r1) begin
          m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
          m_fr[i] = ((m_lfsr % 100) < 30) ? CTRL_BLK : DATA_BLK;
        end else begin
          m_fr[i] = (((g == 0) ? s0[i%4] : s1[i%4]) != 1'b0) ? DATA_BLK : CTRL_BLK;
        end
      end
    end
    e.tally = tally;
    for (int i = 0; i < 8; i++) e.fr[i] = m_fr[i];
    for (int g = 0; g < 2; g++) begin
      e.cod[g] = m_cod[g];
      e.scr[g] = m_scr[g];
    end
    sb.push_back(e);
  endtask

  task automatic drain();
    int t;
    @(posedge clk); #2;
    i_valid = 3'b000;
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    if (sb.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_all(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_frame%0d", tag, i), af[i], '0);
    check({tag, "_coded_f0"}, o_tx_coded_f0, '0);
    check({tag, "_coded_f1"}, o_tx_coded_f1, '0);
    check({tag, "_scr_f0"}, o_tx_scrambled_f0, '0);
    check({tag, "_scr_f1"}, o_tx_scrambled_f1, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) check($sformatf("frame%0d", i), af[i], e.fr[i]);
        check("coded_f0", o_tx_coded_f0, e.cod[0]);
        check("coded_f1", o_tx_coded_f1, e.cod[1]);
        check("scrambled_f0", o_tx_scrambled_f0, e.scr[0]);
        check("scrambled_f1", o_tx_scrambled_f1, e.scr[1]);
        if (e.tally)
          for (int k = 0; k < 4; k++) begin
            tally_blocks++;
            if (af[k][65:64] == 2'b10) ctl_blocks++;
          end
      end
    end
  end

  initial begin : stimulus
    logic [63:0] AA;
    logic [7:0]  txc_r;
    logic [63:0] txd_r;
    int          pct;
    AA = {8{8'hAA}};
    rst_n = 1'b0; i_txd = '0; i_txc = '0; i_data_sel_0 = '0; i_data_sel_1 = '0;
    i_valid = '0; i_enable = 1'b0; i_random_0 = 1'b0; i_random_1 = 1'b0; i_tx_test_mode = 1'b0;
    model_reset();
    #12;
    check_zero_all("reset");
    @(negedge clk); rst_n = 1'b1;

    cyc(3'b111, 1, 4'hF, 4'hF, 0, 0, 0, '0, '0, 0);
    @(posedge clk); #2;
    check("scr_from_reset_nonzero", {256'b0, o_tx_scrambled_f0 != '0}, 257'd1);
    repeat (3) cyc(3'b111, 1, 4'hF, 4'hF, 0, 0, 0, '0, '0, 0);
    drain();
    check("all_data_coded_f0", o_tx_coded_f0, {1'b1, {32{8'hAA}}});
    check("all_data_frame5", o_frame_5, {2'b01, 64'hAAAA_AAAA_AAAA_AAAA});

    repeat (3) cyc(3'b111, 1, 4'h0, 4'hF, 0, 0, 0, '0, '0, 0);
    drain();
    check("all_ctrl_coded_f0", o_tx_coded_f0,
          {1'b0, 4'b0000, 4'hE, 56'h0, {3{64'h1E00_0000_0000_0000}}});
    repeat (3) cyc(3'b111, 1, 4'b0001, 4'hF, 0, 0, 0, '0, '0, 0);
    drain();
    check("mixed_coded_f0", o_tx_coded_f0,
          {1'b0, 4'b1000, {8{8'hAA}}, 4'hE, 56'h0, {2{64'h1E00_0000_0000_0000}}});

    repeat (3) cyc(3'b111, 0, 4'h0, 4'h0, 0, 0, 0, AA, 8'h00, 0);
    drain();
    check("ext_data_coded_f1", o_tx_coded_f1, {1'b1, {32{8'hAA}}});
    repeat (2) cyc(3'b111, 0, 4'h0, 4'h0, 0, 0, 0, {8{8'h07}}, 8'hFF, 0);
    repeat (2) cyc(3'b111, 0, 4'h0, 4'h0, 0, 0, 0, AA, 8'h0F, 0);
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0: txc_r = 8'h00;
        1: txc_r = 8'hFF;
        default: txc_r = 8'($urandom);
      endcase
      txd_r = ($urandom_range(0, 1) != 0) ? {8{8'h07}} : {$urandom, $urandom};
      cyc(3'b111, 0, 4'h0, 4'h0, 0, 0, 0, txd_r, txc_r, 0);
    end

    repeat (3) cyc(3'b111, 1, 4'b0110, 4'b1010, 0, 0, 1, '0, '0, 0);
    drain();
    check("test_mode_scr_eq_coded", o_tx_scrambled_f0, m_cod[0]);

    for (int n = 0; n < 200; n++)
      cyc(3'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), {$urandom, $urandom}, 8'($urandom), 0);

    for (int n = 0; n < 1000; n++)
      cyc(3'b111, 1, 4'($urandom), 4'($urandom), 1, 1'($urandom), 1'($urandom), '0, '0, 1);
    drain();
    pct = (tally_blocks > 0) ? (ctl_blocks * 100) / tally_blocks : 0;
    n_vec++;
    if (pct < 25 || pct > 35) begin
      n_bad++;
      $display("FAIL ctl_fraction actual=%0d%% of %0d blocks required=25..35%%", pct, tally_blocks);
    end

    for (int n = 0; n < 5; n++)
      cyc(3'b000, 1'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1'($urandom), {$urandom, $urandom}, 8'($urandom), 0);
    drain();

    repeat (3) cyc(3'b111, 1, 4'($urandom), 4'($urandom), 1, 0, 0, '0, '0, 0);
    drain();
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_zero_all("midrun_reset");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 6; n++)
      cyc(3'b111, 1, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 0, '0, '0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pcs_257b_tx_generator.md
Name: pcs_257b_tx_generator

Overview:
Stimulus generator for 64b/66b-to-256b/257b BASE-R verification. Each cycle it builds eight 66b blocks in two groups of four (frames 0-3 and 4-7). It transcodes each group into a 257b block (per the 802.3 clause 91 256b/257b scheme) and scrambles each 257b block. Blocks come from internal patterns (fixed or pseudo-random) or from an external 64b XGMII-style word. The pre-scrambler 257b outputs feed the downstream BASE-R 257b checker.

Parameters:
DATA_WIDTH, 64, 66b block payload width
HDR_WIDTH, 2, 66b sync header width
FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH (66), 66b block width
CONTROL_WIDTH, 8, txc width (one bit per byte)
TRANSCODER_BLOCKS, 4, 66b blocks per 257b block
TRANSCODER_WIDTH, 257, transcoded block width
TRANSCODER_HDR_WIDTH, 4, per-block data/ctrl flag field width
PROB, 30, percent probability that a random block is control

Ports:
clk  in  1  clock, all logic rising edge
i_rst_n  in  1  asynchronous active-low reset
i_txd  in  64  external data word (i_enable=0)
i_txc  in  8  external control flags, bit k covers byte k
i_data_sel_0  in  4  per-block type for frames 0-3, bit k = frame k: 1 = data, 0 = control
i_data_sel_1  in  4  same for frames 4-7
i_valid  in  3  [0] update group 0, [1] update group 1, [2] update coded/scrambled registers
i_enable  in  1  1 = internal pattern source, 0 = external i_txd/i_txc
i_random_0  in  1  group 0 block type taken from PRNG instead of i_data_sel_0
i_random_1  in  1  same for group 1
i_tx_test_mode  in  1  1 = scrambler bypass
o_frame_0..o_frame_7  out  66 each  66b blocks; [65:64] sync header, [63:56] first byte
o_tx_coded_f0 / o_tx_coded_f1  out  257  transcoded groups 0 / 1
o_tx_scrambled_f0 / o_tx_scrambled_f1  out  257  scrambled groups 0 / 1

Behaviour:
- Reset (i_rst_n=0, async): all frames, coded and scrambled outputs = 0. Scrambler states = all ones (58 bits). PRNG seed = 32'hACE1_2468.
- Data block: header 2'b01, payload 8 bytes 0xAA (internal mode).
- Control block: header 2'b10, type 0x1E at [63:56], eight 7-bit idle chars = 0 (payload 64'h1E00_0000_0000_0000).
- External mode (i_enable=0): every frame encodes the current i_txd/i_txc.
  - txc=8'h00 -> data block, payload = i_txd.
  - txc=8'hFF with all bytes 0x07 -> idle control block.
  - Any other txc -> error control block: type 0x1E, all 7-bit chars 0x1E.
- Random mode: 32-bit Galois LFSR (x^32+x^22+x^2+x+1), advanced once per block drawn. Block is control when (lfsr mod 100) < PROB, else data.
- Group update: frames of group g register on the clk edge when i_valid[g]=1; otherwise they hold. Latency 1 cycle from inputs to o_frame_*.
- Transcode (combinational from registered frames; registered when i_valid[2]=1, 1 cycle after frames):
  - All 4 blocks data -> [256]=1, [255:0] = 4 payloads, block 0 at MSB end.
  - Otherwise:
    - [256]=0.
    - [255:252] = per-block flags (1 = data), bit 255 = block 0.
    - Then blocks in order: data blocks 64 bits; first control block only its type low nibble plus 56 bits; later control blocks full 64 bits.
- Scramble: self-synchronous 1+x^39+x^58, serially over all 257 bits, bit 256 first. Registered with the coded output (scrambled is 1 cycle after coded). State persists across cycles; f0 and f1 are independent. i_tx_test_mode=1: scrambled = coded, state holds.
- i_valid[2]=0: coded, scrambled and scrambler state hold.
- Reset mid-run clears everything immediately. Generation restarts on the first edge after release.

Test Plan:
- Reset, then i_enable=1, i_valid=7, all sel=4'hF, random off -> each frame {2'b01,64'hAAAA_AAAA_AAAA_AAAA}; coded_f0 = {1'b1, 256 bits of 0xAA repeated}.
- sel_0=4'h0 -> frames 0-3 = {2'b10,64'h1E00_0000_0000_0000}; coded_f0 = {1'b0, 4'b0000, 4'hE, 56'h0, three of 64'h1E00_0000_0000_0000}.
- sel_0=4'b0001 -> frame0 data, frames 1-3 control; coded_f0 = {1'b0, 4'b1000, 64'hAA.., 4'hE, 56'h0, two of 64'h1E00..}.
- i_enable=0, txc=8'h00, txd=64'hAAAA_AAAA_AAAA_AAAA -> all eight frames data; both coded outputs are the all-data pattern.
- i_tx_test_mode=1 -> scrambled equals coded one cycle later. Mode 0 with all-zero coded input from reset state -> nonzero output matching a reference scrambler model.
- i_random_0=1 for 1000 cycles -> control fraction of group-0 blocks is 30% ±5%. i_valid=0 -> all outputs hold.
